mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that serves the instruction cache and the load/store buffer over a single byte-wide RAM port. It is the responder end of the cache's fetch handshake. It accepts a 4-byte instruction fetch or a 1/2/4-byte data access, sequences it byte by byte, and returns one assembled little-endian word with a one-cycle done pulse. It sits between the core (icache, LSB) and the external RAM/IO bus.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all progress
- inst_req  in  1  fetch request from icache, held until inst_rdy
- inst_addr  in  32  fetch byte address (word-aligned)
- inst_rdy  out  1  one-cycle done pulse for fetch
- inst_out  out  32  fetched word, valid while inst_rdy=1
- flush  in  1  abort any instruction fetch (mispredict)
- lsb_req  in  1  data request, held until lsb_rdy
- lsb_wr  in  1  1=store, 0=load
- lsb_len  in  2  access size: 00 byte, 01 half, 11 word
- lsb_addr  in  32  data byte address
- lsb_wdata  in  32  store data, low bytes used
- lsb_rdy  out  1  one-cycle done pulse for data access
- lsb_rdata  out  32  load data, zero-extended, valid while lsb_rdy=1
- mem_din  in  8  RAM read byte, for the address driven the previous cycle
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  IO output buffer full

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration:
  - lsb_req has fixed priority over inst_req.
  - Latch addr, length n (1/2/4; fetch is always 4), wdata and owner.
  - Go to WRITE for stores, READ otherwise.
  - inst_req is ignored in a cycle where flush=1.
- READ:
  - Byte k (k=0..n-1) address is addr+k on mem_a.
  - Byte k is captured from mem_din into bits [8k+7:8k] in the cycle after its address was driven with rdy=1.
  - After the last byte is captured, go to DONE.
- WRITE:
  - Byte k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - After byte n-1 is driven, go to DONE.
  - IO store (addr[17:16]==2'b11) with io_buffer_full=1: mem_wr=0 and the byte does not advance until full clears.
- DONE:
  - Pulse the owner's rdy for one cycle with the data.
  - No request is sampled in DONE, so the requester's held req is not re-accepted.
  - Next state is IDLE.
- flush during a fetch in READ or DONE: go to IDLE next cycle; no inst_rdy.
- flush has no effect on data accesses.
- rdy=0: state, counters and captured bytes hold; mem_wr is forced to 0.
- Unused high bytes of lsb_rdata are 0.

## Timing
- Reset values:
  - state IDLE
  - inst_rdy, lsb_rdy, mem_wr: 0
  - inst_out, lsb_rdata, mem_a, mem_dout: 0
- Word read (request sampled end of cycle 0):
  - mem_a = addr..addr+3 in cycles 1–4.
  - Bytes are captured at the ends of cycles 2–5.
  - The done pulse is in cycle 6.
- Read latency for n bytes: the pulse arrives n+2 cycles after the request is sampled.
- Store of n bytes:
  - mem_wr=1 in cycles 1..n.
  - lsb_rdy pulse in cycle n+1, plus any IO or rdy stall cycles.
- Back-to-back: earliest next acceptance is the cycle after DONE, i.e. one IDLE cycle between transactions.
- Reset mid-transaction: immediate return to IDLE and all outputs to reset values; the partial transfer is dropped.

## Structure
- Shared package riscv_defs holds:
  - lsb_len encodings
  - the IO address decode constant (2'b11 at bits 17:16)
  - the mem_ctrl state enum
- Single module. No sub-module: the arbiter and byte sequencer are small and tightly coupled.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Fetch at 0x100 with RAM holding 13 05 00 00: inst_out=0x00000513 and inst_rdy high in cycle 6 only. mem_a steps 0x100..0x103 and mem_wr stays 0.
- inst_req and lsb_req (load word 0x200) raised in the same cycle: the data access completes first, then the fetch. Between the two, inst_req held high is not double-served.
- Store half 0xBEEF to 0x40: mem_wr=1 for 2 cycles with (0x40,EF), (0x41,BE), and lsb_rdy in cycle 3. A load byte from 0x41 afterwards returns 0x000000BE.
- Store byte to 0x30000 with io_buffer_full=1 for 5 cycles: mem_wr stays 0 during the stall, then one write occurs and lsb_rdy follows one cycle later.
- flush asserted in cycle 3 of a fetch: no inst_rdy, IDLE in cycle 4, and a new fetch is accepted normally afterwards.
- rdy low for 3 cycles during a word read, and rst pulsed mid-store: the read returns the correct word delayed by 3 cycles. After rst, all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared definitions for the memory-side blocks of the core.
//   - lsb_len access-size encodings and a helper that turns one into the
//     index of the last byte of the access
//   - IO region decode tag (address bits 17:16)
//   - mem_ctrl sequencer state and transaction-owner enums
package riscv_defs;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  // Stores whose address has this tag in bits 17:16 go to the IO output buffer.
  localparam logic [1:0] IO_ADDR_TAG = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } mem_state_e;

  typedef enum logic {
    OWNER_INST,
    OWNER_LSB
  } mem_owner_e;

  // Index of the last byte of an access (n-1). The unused encoding 2'b10
  // falls back to a full word.
  function automatic logic [1:0] len_to_last(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      LEN_WORD: return 2'd3;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response bundle of mem_ctrl.
//   inst_*  : icache fetch handshake (req held until inst_rdy pulse)
//   flush   : abort any outstanding instruction fetch
//   lsb_*   : load/store buffer handshake (req held until lsb_rdy pulse)
// Modports: master = requesters (icache + LSB), slave = mem_ctrl.
interface mem_ctrl_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_rdy;
  logic [31:0] inst_out;
  logic        flush;

  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_rdy;
  logic [31:0] lsb_rdata;

  modport master (
    output inst_req, inst_addr, flush,
    output lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
    input  inst_rdy, inst_out, lsb_rdy, lsb_rdata
  );

  modport slave (
    input  inst_req, inst_addr, flush,
    input  lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
    output inst_rdy, inst_out, lsb_rdy, lsb_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves instruction fetches and LSB data accesses over one
// byte-wide RAM port. Each access is sequenced byte by byte and answered
// with one little-endian word and a one-cycle done pulse.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   rdy             : global enable, low freezes all progress
//   core            : mem_ctrl_if.slave (icache + LSB handshakes, flush)
//   mem_din         : RAM read byte for the address driven last cycle
//   mem_dout        : RAM write byte
//   mem_a           : RAM byte address
//   mem_wr          : RAM write strobe
//   io_buffer_full  : IO output buffer full, stalls IO stores
module mem_ctrl
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_ctrl_if.slave   core,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mem_state_e  state_q, state_d;
  mem_owner_e  owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  last_q;   // index of the final byte (n-1)
  logic [2:0]  a_cnt_q;  // bytes whose address has been issued
  logic [2:0]  c_cnt_q;  // bytes captured from mem_din
  logic [31:0] data_q;   // assembled read word

  logic inst_take;
  logic fetch_flush;
  logic io_stall;
  logic pending;
  logic issue;
  logic last_capture;
  logic write_last;
  logic inst_done;
  logic lsb_done;

  assign inst_take    = core.inst_req && !core.flush;
  assign fetch_flush  = (owner_q == OWNER_INST) && core.flush;
  assign io_stall     = (addr_q[17:16] == IO_ADDR_TAG) && io_buffer_full;
  // An address went out last active cycle and its byte is on mem_din now.
  assign pending      = (a_cnt_q != c_cnt_q);
  assign issue        = (a_cnt_q <= {1'b0, last_q});
  assign last_capture = pending && (c_cnt_q == {1'b0, last_q});
  assign write_last   = (a_cnt_q == {1'b0, last_q});

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    inst_done = 1'b0;
    lsb_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdy) begin
          if (core.lsb_req) begin
            state_d = core.lsb_wr ? WRITE : READ;
          end else if (inst_take) begin
            state_d = READ;
          end
        end
      end

      READ: begin
        // While frozen, re-drive the address of the byte still owed so the
        // RAM keeps presenting it on mem_din until capture resumes.
        mem_a = addr_q + 32'(rdy ? a_cnt_q : c_cnt_q);
        if (rdy) begin
          if (fetch_flush) begin
            state_d = IDLE;
          end else if (last_capture) begin
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        mem_a    = addr_q + 32'(a_cnt_q);
        mem_dout = wdata_q[{a_cnt_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !io_stall;
        if (mem_wr && write_last) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (rdy) begin
          inst_done = (owner_q == OWNER_INST) && !core.flush;
          lsb_done  = (owner_q == OWNER_LSB);
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured-word register is reset too, so inst_out/lsb_rdata
  // read as zero after rst rather than leaking a dropped partial transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWNER_INST;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= '0;
      a_cnt_q <= '0;
      c_cnt_q <= '0;
      data_q  <= '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (core.lsb_req) begin
            owner_q <= OWNER_LSB;
            addr_q  <= core.lsb_addr;
            wdata_q <= core.lsb_wdata;
            last_q  <= len_to_last(core.lsb_len);
            a_cnt_q <= '0;
            c_cnt_q <= '0;
            data_q  <= '0;
          end else if (inst_take) begin
            owner_q <= OWNER_INST;
            addr_q  <= core.inst_addr;
            last_q  <= len_to_last(LEN_WORD);
            a_cnt_q <= '0;
            c_cnt_q <= '0;
            data_q  <= '0;
          end
        end

        READ: begin
          if (pending) begin
            data_q[{c_cnt_q[1:0], 3'b000} +: 8] <= mem_din;
            c_cnt_q <= c_cnt_q + 3'd1;
          end
          if (issue) begin
            a_cnt_q <= a_cnt_q + 3'd1;
          end
        end

        WRITE: begin
          if (!io_stall && !write_last) begin
            a_cnt_q <= a_cnt_q + 3'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign core.inst_rdy  = inst_done;
  assign core.lsb_rdy   = lsb_done;
  assign core.inst_out  = data_q;
  // Bytes above the access size were cleared at acceptance: zero-extended.
  assign core.lsb_rdata = data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table-driven transactions with a
// scoreboard queue of expected done pulses, plus hand-written sequences for
// arbitration, IO stall, flush and reset-mid-transfer.
module tb_mem_ctrl;
  import riscv_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl_if core_if ();

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .core           (core_if),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_inst;
    bit          chk;
    logic [31:0] data;
    int          id;
  } exp_t;

  typedef struct {
    bit          is_inst;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
    int          stall_at;
    int          stall_len;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[15];
  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;
  logic [7:0]  ram [0:262143];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input bit is_inst, input bit chk, input logic [31:0] d, input int id);
    exp_t e;
    e = '{is_inst, chk, d, id};
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Byte RAM: registered read of the address driven in the previous cycle.
  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[18'h100] = 8'h13;
    ram[18'h101] = 8'h05;
    ram[18'h102] = 8'h00;
    ram[18'h103] = 8'h00;
    forever begin
      @(posedge clk);
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] = mem_dout;
    end
  end

  // Done-pulse monitor: pops the scoreboard and counts RAM writes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_wr) wr_count++;
      if (core_if.inst_rdy || core_if.lsb_rdy) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", {30'b0, core_if.inst_rdy, core_if.lsb_rdy}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("done_owner[%0d]", e.id), 32'(core_if.inst_rdy), 32'(e.is_inst));
          if (e.chk)
            check($sformatf("done_data[%0d]", e.id),
                  e.is_inst ? core_if.inst_out : core_if.lsb_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic run_txn(input vec_t v, input int id);
    int lat;
    int w0;
    lat = -1;
    next_cycle();
    if (v.is_inst) begin
      core_if.inst_req  = 1'b1;
      core_if.inst_addr = v.addr;
    end else begin
      core_if.lsb_req   = 1'b1;
      core_if.lsb_wr    = v.wr;
      core_if.lsb_len   = v.len;
      core_if.lsb_addr  = v.addr;
      core_if.lsb_wdata = v.wdata;
    end
    sb_push(v.is_inst, v.chk, v.exp_data, id);
    w0 = wr_count;
    for (int k = 1; k <= 60; k++) begin
      next_cycle();
      rdy = !(v.stall_len > 0 && k >= v.stall_at && k < v.stall_at + v.stall_len);
      #1;
      if (core_if.inst_rdy || core_if.lsb_rdy) begin
        lat = k;
        break;
      end
    end
    core_if.inst_req = 1'b0;
    core_if.lsb_req  = 1'b0;
    rdy = 1'b1;
    check($sformatf("latency[%0d]", id), lat, v.exp_lat);
    check($sformatf("writes[%0d]", id), wr_count - w0, v.exp_wr);
  endtask

  initial begin
    logic [31:0] pulses;
    int w0, lsb_at, inst_at, inst_cnt, cnt;

    rdy               = 1'b1;
    io_buffer_full    = 1'b0;
    core_if.inst_req  = 1'b0;
    core_if.inst_addr = '0;
    core_if.flush     = 1'b0;
    core_if.lsb_req   = 1'b0;
    core_if.lsb_wr    = 1'b0;
    core_if.lsb_len   = LEN_BYTE;
    core_if.lsb_addr  = '0;
    core_if.lsb_wdata = '0;

    //          inst  wr    len       addr          wdata          chk   exp_data       lat wr st sl
    vecs[0]  = '{1'b1, 1'b0, LEN_WORD, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0513, 6, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, LEN_WORD, 32'h0000_0200, 32'h0,         1'b1, 32'hA6A7_A4A5, 6, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, LEN_HALF, 32'h0000_0040, 32'h0000_BEEF, 1'b0, 32'h0,         3, 2, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, LEN_BYTE, 32'h0000_0041, 32'h0,         1'b1, 32'h0000_00BE, 3, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, LEN_HALF, 32'h0000_0040, 32'h0,         1'b1, 32'h0000_BEEF, 4, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, LEN_WORD, 32'h0000_0080, 32'h1234_5678, 1'b0, 32'h0,         5, 4, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, LEN_WORD, 32'h0000_0080, 32'h0,         1'b1, 32'h1234_5678, 6, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, LEN_BYTE, 32'h0000_0082, 32'hFFFF_FF99, 1'b0, 32'h0,         2, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, LEN_WORD, 32'h0000_0080, 32'h0,         1'b1, 32'h1299_5678, 6, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, LEN_HALF, 32'h0000_0081, 32'h0,         1'b1, 32'h0000_9956, 4, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, LEN_BYTE, 32'h0000_0003, 32'h0,         1'b1, 32'h0000_00A6, 3, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b0, LEN_WORD, 32'h0000_0200, 32'h0,         1'b1, 32'hA6A7_A4A5, 9, 0, 2, 3};
    vecs[12] = '{1'b0, 1'b1, LEN_WORD, 32'h0000_00C0, 32'hCAFE_F00D, 1'b0, 32'h0,         8, 4, 2, 3};
    vecs[13] = '{1'b0, 1'b0, LEN_WORD, 32'h0000_00C0, 32'h0,         1'b1, 32'hCAFE_F00D, 6, 0, 0, 0};
    vecs[14] = '{1'b1, 1'b0, LEN_WORD, 32'h0000_0204, 32'h0,         1'b1, 32'hA2A3_A0A1, 6, 0, 0, 0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {29'b0, core_if.inst_rdy, core_if.lsb_rdy, mem_wr}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_inst_out", core_if.inst_out, 32'h0);
    check("rst_lsb_rdata", core_if.lsb_rdata, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;

    // Fetch at 0x100, cycle by cycle.
    next_cycle();
    core_if.inst_req  = 1'b1;
    core_if.inst_addr = 32'h100;
    sb_push(1'b1, 1'b1, 32'h0000_0513, 100);
    w0 = wr_count;
    pulses = '0;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      #1;
      if (k <= 4) check($sformatf("fetch_mem_a[%0d]", k), mem_a, 32'h100 + 32'(k - 1));
      if (core_if.inst_rdy) pulses = pulses | (32'h1 << k);
      if (k == 6) core_if.inst_req = 1'b0;
    end
    check("fetch_pulse_cycles", pulses, 32'h40);
    check("fetch_no_write", wr_count - w0, 0);

    // Table-driven transactions.
    for (int i = 0; i < 15; i++) run_txn(vecs[i], i);

    // Simultaneous requests: data first, fetch served exactly once after.
    next_cycle();
    core_if.inst_req  = 1'b1;
    core_if.inst_addr = 32'h100;
    core_if.lsb_req   = 1'b1;
    core_if.lsb_wr    = 1'b0;
    core_if.lsb_len   = LEN_WORD;
    core_if.lsb_addr  = 32'h200;
    sb_push(1'b0, 1'b1, 32'hA6A7_A4A5, 200);
    sb_push(1'b1, 1'b1, 32'h0000_0513, 201);
    lsb_at = -1; inst_at = -1; inst_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      next_cycle();
      #1;
      if (core_if.lsb_rdy) begin
        lsb_at = k;
        core_if.lsb_req = 1'b0;
      end
      if (core_if.inst_rdy) begin
        inst_cnt++;
        inst_at = k;
        core_if.inst_req = 1'b0;
      end
    end
    check("arb_lsb_cycle", lsb_at, 6);
    check("arb_inst_cycle", inst_at, 13);
    check("arb_inst_count", inst_cnt, 1);

    // IO store stalled by a full output buffer for 5 cycles.
    next_cycle();
    core_if.lsb_req   = 1'b1;
    core_if.lsb_wr    = 1'b1;
    core_if.lsb_len   = LEN_BYTE;
    core_if.lsb_addr  = 32'h0003_0000;
    core_if.lsb_wdata = 32'h0000_00C3;
    io_buffer_full    = 1'b1;
    sb_push(1'b0, 1'b0, 32'h0, 300);
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      #1;
      if (mem_wr) cnt++;
    end
    check("io_stall_writes", cnt, 0);
    next_cycle();
    io_buffer_full = 1'b0;
    #1;
    check("io_write_strobe", {31'b0, mem_wr}, 32'h1);
    check("io_write_addr", mem_a, 32'h0003_0000);
    check("io_write_data", {24'b0, mem_dout}, 32'hC3);
    next_cycle();
    #1;
    check("io_lsb_rdy", {31'b0, core_if.lsb_rdy}, 32'h1);
    core_if.lsb_req = 1'b0;
    check("io_ram", {24'b0, ram[18'h30000]}, 32'hC3);

    // Flush in cycle 3 of a fetch.
    next_cycle();
    core_if.inst_req  = 1'b1;
    core_if.inst_addr = 32'h100;
    next_cycle();
    next_cycle();
    next_cycle();
    core_if.inst_req = 1'b0;
    core_if.flush    = 1'b1;
    next_cycle();
    core_if.flush = 1'b0;
    #1;
    check("flush_idle", 32'(dut.state_q), 32'(IDLE));
    cnt = 0;
    repeat (8) begin
      next_cycle();
      #1;
      if (core_if.inst_rdy) cnt++;
    end
    check("flush_no_rdy", cnt, 0);
    run_txn(vecs[0], 400);

    // Reset pulsed in the middle of a word store.
    next_cycle();
    core_if.lsb_req   = 1'b1;
    core_if.lsb_wr    = 1'b1;
    core_if.lsb_len   = LEN_WORD;
    core_if.lsb_addr  = 32'h300;
    core_if.lsb_wdata = 32'h1122_3344;
    sb_push(1'b0, 1'b0, 32'h0, 500);
    next_cycle();
    next_cycle();
    #1;
    check("pre_rst_write", {31'b0, mem_wr}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {29'b0, core_if.inst_rdy, core_if.lsb_rdy, mem_wr}, 32'h0);
    check("mid_rst_mem_a", mem_a, 32'h0);
    check("mid_rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    check("mid_rst_inst_out", core_if.inst_out, 32'h0);
    check("mid_rst_lsb_rdata", core_if.lsb_rdata, 32'h0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    core_if.lsb_req = 1'b0;
    sb_q.delete();
    next_cycle();
    rst = 1'b0;
    run_txn(vecs[0], 501);

    repeat (3) next_cycle();
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
